// File: rtl/alu_pkg.sv
// Shared opcodes, PSR bit positions and FSM states for the sequential ALU.
// ALU_MUL_EN adds the MUL state to the state enum.
package alu_pkg;

  localparam logic [5:0] OP_AND  = 6'b000001;
  localparam logic [5:0] OP_OR   = 6'b000010;
  localparam logic [5:0] OP_XOR  = 6'b000011;
  localparam logic [5:0] OP_ADD  = 6'b000101;
  localparam logic [5:0] OP_ADDU = 6'b000110;
  localparam logic [5:0] OP_SUB  = 6'b001001;
  localparam logic [5:0] OP_CMP  = 6'b001011;
  localparam logic [5:0] OP_MOV  = 6'b001101;
  localparam logic [5:0] OP_MUL  = 6'b001110;
  localparam logic [5:0] OP_LSHI = 6'b100000;
  localparam logic [5:0] OP_LSH  = 6'b100101;
  localparam logic [5:0] OP_LUI  = 6'b111111;

  localparam int PSR_C = 0;
  localparam int PSR_L = 2;
  localparam int PSR_F = 5;
  localparam int PSR_Z = 6;
  localparam int PSR_N = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1
`ifdef ALU_MUL_EN
    ,
    ST_MUL   = 2'd2
`endif
  } state_t;

endpackage

// File: rtl/alu_iter_unit.sv
// Iterative datapath: one-bit-per-cycle shifter and, with ALU_MUL_EN,
// a shift-add multiplier. o_result is the value produced on the done edge.
module alu_iter_unit #(
  parameter int WIDTH    = 16,
  parameter int CNT_BITS = $clog2(WIDTH) + 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_start,
`ifdef ALU_MUL_EN
  input  logic                i_is_mul,
  input  logic [WIDTH-1:0]    i_b,
`endif
  input  logic                i_dir_right,
  input  logic [CNT_BITS-1:0] i_count,
  input  logic [WIDTH-1:0]    i_a,
  output logic                o_done,
  output logic [WIDTH-1:0]    o_result
);

  logic [WIDTH-1:0]    r_data;
  logic [CNT_BITS-1:0] r_cnt;
  logic                r_right;
  logic [WIDTH-1:0]    w_data_next;

`ifdef ALU_MUL_EN
  logic                r_is_mul;
  logic [WIDTH-1:0]    r_mplier;
  logic [WIDTH-1:0]    r_acc;
  logic [WIDTH-1:0]    w_acc_next;

  assign w_acc_next = r_acc + (r_mplier[0] ? r_data : {WIDTH{1'b0}});
  assign o_result   = r_is_mul ? w_acc_next : w_data_next;
`else
  assign o_result   = w_data_next;
`endif

  assign w_data_next = r_right ? (r_data >> 1) : (r_data << 1);
  assign o_done      = (r_cnt == CNT_BITS'(1'b1));

  // Load on start, then step once per cycle until the counter drains.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_data   <= {WIDTH{1'b0}};
      r_cnt    <= {CNT_BITS{1'b0}};
      r_right  <= 1'b0;
`ifdef ALU_MUL_EN
      r_is_mul <= 1'b0;
      r_mplier <= {WIDTH{1'b0}};
      r_acc    <= {WIDTH{1'b0}};
`endif
    end else if (i_start) begin
      r_data   <= i_a;
      r_cnt    <= i_count;
`ifdef ALU_MUL_EN
      r_is_mul <= i_is_mul;
      r_mplier <= i_b;
      r_acc    <= {WIDTH{1'b0}};
      r_right  <= i_dir_right && !i_is_mul;
`else
      r_right  <= i_dir_right;
`endif
    end else if (r_cnt != {CNT_BITS{1'b0}}) begin
      r_data   <= w_data_next;
      r_cnt    <= r_cnt - CNT_BITS'(1'b1);
`ifdef ALU_MUL_EN
      r_mplier <= r_mplier >> 1;
      r_acc    <= w_acc_next;
`endif
    end
  end

endmodule

// File: rtl/alu_seq_unit.sv
// Registered multi-cycle ALU with owned PSR and valid/ready handshake.
// Define ALU_MUL_EN to compile in the iterative shift-add multiplier.
module alu_seq_unit
  import alu_pkg::*;
#(
  parameter int WIDTH         = 16,
  parameter int ALU_CONT_BITS = 6,
  parameter int CNT_BITS      = $clog2(WIDTH) + 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         a,
  input  logic [WIDTH-1:0]         b,
  input  logic [ALU_CONT_BITS-1:0] alu_cont,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         alu_out,
  output logic [WIDTH-1:0]         psr_flags
);

  state_t              r_state;
  state_t              w_state_next;
  logic [WIDTH-1:0]    r_alu_out;
  logic [WIDTH-1:0]    r_psr;
  logic                r_out_valid;

  logic                w_accept;
  logic [WIDTH:0]      w_add;
  logic [WIDTH-1:0]    w_sub;
  logic [WIDTH-1:0]    w_b_mag;
  logic [CNT_BITS-1:0] w_shift_n;
  logic [CNT_BITS-1:0] w_iter_count;
  logic [WIDTH-1:0]    w_result;
  logic [WIDTH-1:0]    w_psr_next;
  logic                w_keep_out;
  logic                w_go_shift;
  logic                w_go_mul;
  logic                w_iter_start;
  logic                w_iter_done;
  logic [WIDTH-1:0]    w_iter_result;

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = r_out_valid;
  assign alu_out   = r_alu_out;
  assign psr_flags = r_psr;
  assign w_accept  = in_valid && in_ready;

  assign w_add   = {1'b0, a} + {1'b0, b};
  assign w_sub   = a - b;
  // b is a signed shift amount; its magnitude saturates at WIDTH.
  assign w_b_mag   = b[WIDTH-1] ? (~b + WIDTH'(1'b1)) : b;
  assign w_shift_n = (w_b_mag >= WIDTH'(WIDTH)) ? CNT_BITS'(WIDTH) : w_b_mag[CNT_BITS-1:0];

  assign w_iter_start = w_accept && (w_go_shift || w_go_mul);
  assign w_iter_count = w_go_mul ? CNT_BITS'(WIDTH) : w_shift_n;

  // Single-cycle result, PSR next value and long-op dispatch decode.
  always_comb begin
    w_result   = {WIDTH{1'b0}};
    w_psr_next = r_psr;
    w_keep_out = 1'b0;
    w_go_shift = 1'b0;
    w_go_mul   = 1'b0;
    case (alu_cont)
      OP_AND:  w_result = a & b;
      OP_OR:   w_result = a | b;
      OP_XOR:  w_result = a ^ b;
      OP_ADD: begin
        w_result          = w_add[WIDTH-1:0];
        w_psr_next[PSR_C] = w_add[WIDTH];
        w_psr_next[PSR_F] = (a[WIDTH-1] == b[WIDTH-1]) && (w_add[WIDTH-1] != a[WIDTH-1]);
      end
      OP_ADDU: w_result = w_add[WIDTH-1:0];
      OP_SUB: begin
        w_result          = w_sub;
        w_psr_next[PSR_C] = (a < b);
        w_psr_next[PSR_F] = (a[WIDTH-1] != b[WIDTH-1]) && (w_sub[WIDTH-1] != a[WIDTH-1]);
      end
      OP_CMP: begin
        w_keep_out        = 1'b1;
        w_psr_next[PSR_N] = ($signed(a) < $signed(b));
        w_psr_next[PSR_L] = (a < b);
        w_psr_next[PSR_Z] = (a == b);
      end
      OP_MOV:  w_result = b;
      OP_LUI:  w_result = b << 4'd8;
      OP_LSH, OP_LSHI: begin
        w_result   = a;
        w_go_shift = (w_shift_n != {CNT_BITS{1'b0}});
      end
`ifdef ALU_MUL_EN
      OP_MUL:  w_go_mul = 1'b1;
`endif
      default: w_result = {WIDTH{1'b0}};
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && w_go_shift) begin
          w_state_next = ST_SHIFT;
`ifdef ALU_MUL_EN
        end else if (w_accept && w_go_mul) begin
          w_state_next = ST_MUL;
`endif
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_SHIFT: w_state_next = w_iter_done ? ST_IDLE : ST_SHIFT;
`ifdef ALU_MUL_EN
      ST_MUL:   w_state_next = w_iter_done ? ST_IDLE : ST_MUL;
`endif
      default:  w_state_next = ST_IDLE;
    endcase
  end

  // Result, PSR and completion pulse; CMP updates flags but keeps alu_out.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_alu_out   <= {WIDTH{1'b0}};
      r_psr       <= {WIDTH{1'b0}};
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      if (w_accept && !w_iter_start) begin
        if (!w_keep_out) begin
          r_alu_out <= w_result;
        end
        r_psr       <= w_psr_next;
        r_out_valid <= 1'b1;
      end else if (w_iter_done) begin
        r_alu_out   <= w_iter_result;
        r_out_valid <= 1'b1;
      end
    end
  end

  alu_iter_unit #(
    .WIDTH    (WIDTH),
    .CNT_BITS (CNT_BITS)
  ) u_iter (
    .clk         (clk),
    .reset       (reset),
    .i_start     (w_iter_start),
`ifdef ALU_MUL_EN
    .i_is_mul    (w_go_mul),
    .i_b         (b),
`endif
    .i_dir_right (b[WIDTH-1]),
    .i_count     (w_iter_count),
    .i_a         (a),
    .o_done      (w_iter_done),
    .o_result    (w_iter_result)
  );

endmodule

// File: tb/tb_alu_seq_unit.sv
// Directed self-checking bench for alu_seq_unit; MUL expectations follow ALU_MUL_EN.
module tb_alu_seq_unit;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic [5:0]  alu_cont;
  logic        out_valid;
  logic [15:0] alu_out;
  logic [15:0] psr_flags;

  int n_vec;
  int n_err;
  int lat;

  alu_seq_unit #(.WIDTH(16), .ALU_CONT_BITS(6)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .alu_cont  (alu_cont),
    .out_valid (out_valid),
    .alu_out   (alu_out),
    .psr_flags (psr_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Offer one op for one cycle, then count cycles up to out_valid (bounded).
  task automatic run_op(input logic [5:0] op, input logic [15:0] av, input logic [15:0] bv,
                        output int l);
    alu_cont = op;
    a        = av;
    b        = bv;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    l = 1;
    while (out_valid !== 1'b1 && l < 40) begin
      step();
      l++;
    end
  endtask

  initial begin
    n_vec    = 0;
    n_err    = 0;
    reset    = 1'b1;
    in_valid = 1'b0;
    a        = 16'h0000;
    b        = 16'h0000;
    alu_cont = 6'b000000;
    repeat (2) step();
    reset = 1'b0;
    check("rst_out",   {16'h0, alu_out}, 32'h0000);
    check("rst_psr",   {16'h0, psr_flags}, 32'h0000);
    check("rst_valid", {31'h0, out_valid}, 32'h0);
    check("rst_ready", {31'h0, in_ready}, 32'h1);

    run_op(6'b000101, 16'h7FFF, 16'h0001, lat);
    check("add_lat", lat, 1);
    check("add_out", {16'h0, alu_out}, 32'h8000);
    check("add_psr", {16'h0, psr_flags}, 32'h0020);

    run_op(6'b001001, 16'h0003, 16'h0005, lat);
    check("sub_out", {16'h0, alu_out}, 32'hFFFE);
    check("sub_psr", {16'h0, psr_flags}, 32'h0001);

    run_op(6'b001011, 16'hFFFF, 16'h0001, lat);
    check("cmp1_out", {16'h0, alu_out}, 32'hFFFE);
    check("cmp1_psr", {16'h0, psr_flags}, 32'h0081);

    // Back-to-back single-cycle ops with in_valid held high.
    in_valid = 1'b1;
    a = 16'hF0F0; b = 16'h3C3C; alu_cont = 6'b000001; step();
    check("and_v", {31'h0, out_valid}, 32'h1);
    check("and_out", {16'h0, alu_out}, 32'h3030);
    alu_cont = 6'b000010; step();
    check("or_v", {31'h0, out_valid}, 32'h1);
    check("or_out", {16'h0, alu_out}, 32'hFCFC);
    alu_cont = 6'b000011; step();
    check("xor_v", {31'h0, out_valid}, 32'h1);
    check("xor_out", {16'h0, alu_out}, 32'hCCCC);
    b = 16'h1234; alu_cont = 6'b001101; step();
    check("mov_v", {31'h0, out_valid}, 32'h1);
    check("mov_out", {16'h0, alu_out}, 32'h1234);
    b = 16'h00AB; alu_cont = 6'b111111; step();
    check("lui_v", {31'h0, out_valid}, 32'h1);
    check("lui_out", {16'h0, alu_out}, 32'hAB00);
    in_valid = 1'b0;
    step();
    check("idle_v", {31'h0, out_valid}, 32'h0);
    check("hold_out", {16'h0, alu_out}, 32'hAB00);
    check("b2b_psr", {16'h0, psr_flags}, 32'h0081);

    run_op(6'b000110, 16'hFFFF, 16'h0002, lat);
    check("addu_out", {16'h0, alu_out}, 32'h0001);
    check("addu_psr", {16'h0, psr_flags}, 32'h0081);

    // LSH by 4: busy for cycles 1-4, result at cycle 5.
    alu_cont = 6'b100101; a = 16'h0001; b = 16'h0004; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      check("lsh_busy", {30'h0, in_ready, out_valid}, 32'h0);
      step();
    end
    check("lsh_v", {31'h0, out_valid}, 32'h1);
    check("lsh_rdy", {31'h0, in_ready}, 32'h1);
    check("lsh_out", {16'h0, alu_out}, 32'h0010);

    run_op(6'b100000, 16'h8000, 16'hFFFC, lat);
    check("lshr_lat", lat, 5);
    check("lshr_out", {16'h0, alu_out}, 32'h0800);
    run_op(6'b100101, 16'hFFFF, 16'h0011, lat);
    check("lsh17_lat", lat, 17);
    check("lsh17_out", {16'h0, alu_out}, 32'h0000);
    run_op(6'b100000, 16'hFFFF, 16'hFFF0, lat);
    check("lshr16_lat", lat, 17);
    check("lshr16_out", {16'h0, alu_out}, 32'h0000);
    run_op(6'b100101, 16'h5A5A, 16'h0000, lat);
    check("lsh0_lat", lat, 1);
    check("lsh0_out", {16'h0, alu_out}, 32'h5A5A);
    check("shift_psr", {16'h0, psr_flags}, 32'h0081);

    // Inputs offered while busy are ignored, then accepted on the out_valid cycle.
    alu_cont = 6'b100101; a = 16'h0003; b = 16'h0002; in_valid = 1'b1;
    step();
    alu_cont = 6'b001101; b = 16'hDEAD;
    step();
    check("busy_v", {31'h0, out_valid}, 32'h0);
    step();
    check("busy_res_v", {31'h0, out_valid}, 32'h1);
    check("busy_res", {16'h0, alu_out}, 32'h000C);
    step();
    in_valid = 1'b0;
    check("after_v", {31'h0, out_valid}, 32'h1);
    check("after_out", {16'h0, alu_out}, 32'hDEAD);

    run_op(6'b001110, 16'h0012, 16'h0034, lat);
`ifdef ALU_MUL_EN
    check("mul_lat", lat, 17);
    check("mul_out", {16'h0, alu_out}, 32'h03A8);
`else
    check("mul_lat", lat, 1);
    check("mul_out", {16'h0, alu_out}, 32'h0000);
`endif
    check("mul_psr", {16'h0, psr_flags}, 32'h0081);

    run_op(6'b010101, 16'h1111, 16'h2222, lat);
    check("unk_lat", lat, 1);
    check("unk_out", {16'h0, alu_out}, 32'h0000);

    run_op(6'b000101, 16'h8000, 16'h8000, lat);
    check("addcf_out", {16'h0, alu_out}, 32'h0000);
    check("addcf_psr", {16'h0, psr_flags}, 32'h00A1);
    run_op(6'b001011, 16'h0005, 16'h0005, lat);
    check("cmpz_psr", {16'h0, psr_flags}, 32'h0061);
    run_op(6'b001011, 16'h0001, 16'hFFFF, lat);
    check("cmpl_psr", {16'h0, psr_flags}, 32'h0025);

    // Reset during cycle 3 of an 8-step shift.
    alu_cont = 6'b100101; a = 16'h0001; b = 16'h0008; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mrst_v", {31'h0, out_valid}, 32'h0);
    check("mrst_out", {16'h0, alu_out}, 32'h0000);
    check("mrst_psr", {16'h0, psr_flags}, 32'h0000);
    check("mrst_rdy", {31'h0, in_ready}, 32'h1);
    for (int k = 0; k < 8; k++) begin
      step();
      check("mrst_quiet", {31'h0, out_valid}, 32'h0);
    end
    run_op(6'b000101, 16'h0002, 16'h0003, lat);
    check("post_lat", lat, 1);
    check("post_out", {16'h0, alu_out}, 32'h0005);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
